ahb_sram_ctrl: RTL
==================

# ahb_sram_ctrl

AHB-Lite slave that acts as the initiator for a single-port synchronous SRAM (the `ram_1port` cell: `wen`/`cen`/`addr`/`data` in, registered `q` out, one-cycle read latency, no byte enables). It sits between a bus-matrix slave port and one SRAM bank. It converts pipelined AHB transfers into SRAM accesses, inserting wait states for reads and for read-modify-write of sub-word stores.

## Interface
Parameters:
- `ADDR_WIDTH`, 12: SRAM word-address width. The bank is 4·2^ADDR_WIDTH bytes. Data width is fixed at 32.

Ports:
- `clk`  in  1  single clock for the AHB and SRAM sides.
- `rstn`  in  1  asynchronous, active-low reset.
- `hsel`  in  1  slave select.
- `htrans`  in  2  transfer type; bit 1 set means NONSEQ/SEQ.
- `hwrite`  in  1  1 = write.
- `hsize`  in  3  0 = byte, 1 = halfword, ≥2 = word.
- `haddr`  in  32  byte address. Only bits `[ADDR_WIDTH+1:0]` are used; upper bits are ignored, so accesses alias.
- `hwdata`  in  32  write data, valid in the data phase.
- `hready`  in  1  bus-level ready; qualifies address phases.
- `hreadyout`  out  1  slave ready.
- `hresp`  out  1  tied 0 (OKAY).
- `hrdata`  out  32  read data.
- `ram_cen`  out  1  SRAM chip enable.
- `ram_wen`  out  1  SRAM write enable; 0 with `ram_cen`=1 means read.
- `ram_addr`  out  ADDR_WIDTH  SRAM word address, equal to `haddr[ADDR_WIDTH+1:2]` of the registered address phase.
- `ram_data`  out  32  SRAM write data.
- `ram_q`  in  32  SRAM read data. Valid only in the cycle after a read issue; X otherwise.

## Operation
- An address phase is accepted when `hsel & htrans[1] & hready`. On acceptance, `haddr`, `hwrite`, and `hsize` are registered. IDLE and BUSY transfers are ignored and complete with zero wait.
- FSM states: IDLE, WR_WORD, RD_REQ, RD_RESP, RMW_RD, RMW_WR.
- The accepted transfer selects the next state:
  - word write → WR_WORD;
  - read → RD_REQ;
  - sub-word write → RMW_RD.
- A new accepted address phase in the final data-phase cycle (`hreadyout`=1) chains directly to its next state. Otherwise the FSM returns to IDLE.
- WR_WORD: `ram_cen`=1, `ram_wen`=1, `ram_data`=`hwdata`, `hreadyout`=1.
- RD_REQ: `ram_cen`=1, `ram_wen`=0, `hreadyout`=0.
- RD_RESP: `hrdata`=`ram_q`, `hreadyout`=1, no SRAM access.
- RMW_RD: read the word at `ram_addr`, `hreadyout`=0.
- RMW_WR: `ram_cen`=1, `ram_wen`=1, `ram_data` = `ram_q` with the selected lanes replaced from `hwdata`, `hreadyout`=1. Lane selection is little-endian:
  - byte: lane `haddr[1:0]`;
  - halfword: lanes `{haddr[1],0}` and `{haddr[1],1}`. `haddr[0]` is ignored.
- `hrdata` is 0 outside RD_RESP. `ram_q` is never sampled outside RD_RESP and RMW_WR.
- In IDLE: `ram_cen`=0, `ram_wen`=0, `hreadyout`=1.
- Read-after-write to the same word returns the new data. The write commits at the clock edge ending its data phase, and the read is issued afterwards.

## Timing
- Reset values: state IDLE, `hreadyout`=1, `hresp`=0, `hrdata`=0, `ram_cen`=0, `ram_wen`=0, `ram_addr`=0, `ram_data`=0.
- Data-phase length:
  - word write: 1 cycle (0 wait);
  - read: 2 cycles (1 wait);
  - sub-word write: 2 cycles (1 wait).
- Back-to-back throughput:
  - word writes: 1 transfer per cycle;
  - reads: 1 per 2 cycles.
- If `rstn` is asserted mid-transfer, the FSM goes to IDLE immediately and `ram_cen` drops asynchronously. A partially completed RMW never writes.
- While `hreadyout`=0, no new address phase is accepted. `hready` is low, so the next phase is held by the master.

## Configuration
- `AHB_SRAM_RMW_EN` defined: sub-word writes use RMW_RD → RMW_WR as described above.
- `AHB_SRAM_RMW_EN` undefined:
  - the RMW states are not compiled;
  - sub-word writes go to WR_WORD and write all 32 bits of `hwdata` with zero wait;
  - masters must replicate data across lanes.

## Test plan
- Reset check: reset, then idle bus → `hreadyout`=1, `hrdata`=0, `ram_cen`=0 every cycle.
- Word write then read:
  - stimulus: word write 0xDEADBEEF @0x10, then read @0x10;
  - response: `ram_addr`=4 for both accesses, the write has 0 wait, the read has 1 wait, `hrdata`=0xDEADBEEF.
- Byte RMW (RMW_EN defined):
  - stimulus: word 0x11223344 @0x0, byte write 0xAA @0x2 (`hwdata`=0x00AA0000), then read @0x0;
  - response: 1 wait on the byte write, read returns 0x11AA3344.
- Halfword RMW without RMW_EN:
  - stimulus: halfword write `hwdata`=0x5566_7788 @0x2;
  - response: 0 wait, full word 0x55667788 stored.
- Pipelined mix:
  - stimulus: write A, read A, write B, read B on consecutive address phases;
  - response: correct data for both reads, with `hreadyout` low exactly one cycle per read.
- Reset abort:
  - stimulus: assert `rstn` low during RMW_RD of a byte write;
  - response: the SRAM word is unchanged, and the FSM is in IDLE after reset release.

Source files
------------

// File: rtl/ahb_sram_ctrl.sv
// AHB-Lite slave acting as initiator for a single-port synchronous SRAM (one-cycle read latency).
// Define AHB_SRAM_RMW_EN to build read-modify-write support for byte/halfword stores.
module ahb_sram_ctrl #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  hsel,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [31:0]           haddr,
  input  logic [31:0]           hwdata,
  input  logic                  hready,
  output logic                  hreadyout,
  output logic                  hresp,
  output logic [31:0]           hrdata,
  output logic                  ram_cen,
  output logic                  ram_wen,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_data,
  input  logic [31:0]           ram_q
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_WORD = 3'd1,
    RD_REQ  = 3'd2,
    RD_RESP = 3'd3
`ifdef AHB_SRAM_RMW_EN
    ,
    RMW_RD  = 3'd4,
    RMW_WR  = 3'd5
`endif
  } state_t;

  state_t                  state, state_nxt, xfer_state;
  logic                    accept;
  logic [ADDR_WIDTH-1:0]   addr_p1;
  logic                    unused_bits;

`ifdef AHB_SRAM_RMW_EN
  logic [1:0]              lane_p1;
  logic                    half_p1;

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [1:0]  lane,
                                              input logic        half);
    logic [3:0]  be;
    logic [31:0] res;
    be = half ? (lane[1] ? 4'b1100 : 4'b0011) : (4'b0001 << lane);
    for (int i = 0; i < 4; i++)
      res[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    return res;
  endfunction

  assign unused_bits = ^{htrans[0], haddr[31:ADDR_WIDTH+2]};
`else
  assign unused_bits = ^{htrans[0], haddr[31:ADDR_WIDTH+2], haddr[1:0], hsize};
`endif

  assign accept   = hsel & htrans[1] & hready;
  assign hresp    = 1'b0;
  assign ram_addr = addr_p1;

  always_comb begin
    xfer_state = RD_REQ;
    if (hwrite) begin
      xfer_state = WR_WORD;
`ifdef AHB_SRAM_RMW_EN
      if (hsize < 3'd2)
        xfer_state = RMW_RD;
`endif
    end
  end

  // Address phase -> data phase boundary
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      addr_p1 <= '0;
`ifdef AHB_SRAM_RMW_EN
      lane_p1 <= '0;
      half_p1 <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (accept) begin
        addr_p1 <= haddr[ADDR_WIDTH+1:2];
`ifdef AHB_SRAM_RMW_EN
        lane_p1 <= haddr[1:0];
        half_p1 <= (hsize == 3'd1);
`endif
      end
    end
  end

  always_comb begin
    state_nxt = IDLE;
    hreadyout = 1'b1;
    ram_cen   = 1'b0;
    ram_wen   = 1'b0;
    ram_data  = '0;
    hrdata    = '0;
    case (state)
      WR_WORD: begin
        ram_cen  = 1'b1;
        ram_wen  = 1'b1;
        ram_data = hwdata;
      end
      RD_REQ: begin
        ram_cen   = 1'b1;
        hreadyout = 1'b0;
        state_nxt = RD_RESP;
      end
      RD_RESP: begin
        hrdata = ram_q;
      end
`ifdef AHB_SRAM_RMW_EN
      RMW_RD: begin
        ram_cen   = 1'b1;
        hreadyout = 1'b0;
        state_nxt = RMW_WR;
      end
      RMW_WR: begin
        ram_cen  = 1'b1;
        ram_wen  = 1'b1;
        ram_data = merge_lanes(ram_q, hwdata, lane_p1, half_p1);
      end
`endif
      default: ;
    endcase
    // Only the final data-phase cycle may chain into the next transfer
    if (hreadyout && accept)
      state_nxt = xfer_state;
  end

endmodule
